// File: rtl/data_bus_bridge_pkg.sv
// data_bus_bridge_pkg
// Shared definitions for the core data-bus bridge: FSM state encoding,
// the default access timeout and the cause code handed to the exception
// unit when an access is aborted.
package data_bus_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } busState_t;

  // BUSY cycles without an ack before an access is abandoned.
  localparam int unsigned DBUS_TIMEOUT_DEFAULT = 255;

  // Cause code reported to the exception unit alongside oBusError.
  localparam logic [3:0] DBUS_ERR_CAUSE = 4'd5;

  // Timeout counter width: one spare bit so the terminal value always fits.
  function automatic int unsigned dbusCounterWidth(input int unsigned timeoutCycles);
    return $clog2(timeoutCycles) + 1;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter
// Saturating cycle counter used to bound how long the bridge waits for an ack.
//   iCLK, iRST : clock, asynchronous active-high reset
//   iClear     : synchronous clear (wins over iEnable)
//   iEnable    : count one cycle
//   oTerminal  : count equals TIMEOUT_CYCLES-1
module bus_timeout_counter
  import data_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClear,
  input  logic iEnable,
  output logic oTerminal
);

  localparam int unsigned CW = dbusCounterWidth(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TermCount = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MaxCount  = '1;

  logic [CW-1:0] countQ;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      countQ <= '0;
    end else if (iClear) begin
      countQ <= '0;
    end else if (iEnable && (countQ != MaxCount)) begin
      // Holds at all-ones rather than wrapping back to zero.
      countQ <= countQ + CW'(1);
    end
  end

  assign oTerminal = (countQ == TermCount);

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge
// Bridges the single-cycle core data bus onto a req/ack memory bus. A core
// load/store is captured in IDLE, presented on the memory side while BUSY
// until acked or timed out, and retired by the core in the DONE cycle.
//   iCLK, iRST                     : clock, asynchronous active-high reset
//   iCoreRead/iCoreWrite           : core load / store request
//   iCoreByteEnable/Address/WData  : core access attributes
//   oCoreReadData                  : load data back to the core
//   oCoreStall                     : combinational core hold
//   oMemReq/We/ByteEnable/Address/WriteData : registered memory-side access
//   iMemReadData, iMemAck          : memory response
//   oBusError, oErrAddress         : timeout pulse and faulting address
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCoreRead,
  input  logic        iCoreWrite,
  input  logic [3:0]  iCoreByteEnable,
  input  logic [31:0] iCoreAddress,
  input  logic [31:0] iCoreWriteData,
  output logic [31:0] oCoreReadData,
  output logic        oCoreStall,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [3:0]  oMemByteEnable,
  output logic [31:0] oMemAddress,
  output logic [31:0] oMemWriteData,
  input  logic [31:0] iMemReadData,
  input  logic        iMemAck,
  output logic        oBusError,
  output logic [31:0] oErrAddress
);

  busState_t state;
  logic      access;
  logic      timeoutHit;

  assign access = iCoreRead | iCoreWrite;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iClear   ((state == StIdle) && access),
    .iEnable  ((state == StBusy) && !iMemAck),
    .oTerminal(timeoutHit)
  );

  // Stall must be combinational so the core holds in the very cycle it issues.
  assign oCoreStall = ((state == StIdle) && access) || (state == StBusy);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state          <= StIdle;
      oMemReq        <= 1'b0;
      oMemWe         <= 1'b0;
      oMemByteEnable <= '0;
      oMemAddress    <= '0;
      oMemWriteData  <= '0;
      oCoreReadData  <= '0;
      oBusError      <= 1'b0;
      oErrAddress    <= '0;
    end else begin
      oBusError <= 1'b0;
      unique case (state)
        StIdle: begin
          if (access) begin
            // A simultaneous read and write is treated as a write.
            oMemWe         <= iCoreWrite;
            oMemByteEnable <= iCoreByteEnable;
            oMemAddress    <= iCoreAddress;
            oMemWriteData  <= iCoreWriteData;
            oMemReq        <= 1'b1;
            state          <= StBusy;
          end
        end
        StBusy: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (iMemAck) begin
            if (!oMemWe) begin
              oCoreReadData <= iMemReadData;
            end
            oMemReq <= 1'b0;
            state   <= StDone;
          end else if (timeoutHit) begin
            oCoreReadData <= '0;
            oBusError     <= 1'b1;
            oErrAddress   <= oMemAddress;
            oMemReq       <= 1'b0;
            state         <= StDone;
          end
        end
        StDone: begin
          // Core retires here; a new access is only seen back in IDLE.
          state <= StIdle;
        end
        default: begin
          oMemReq <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Testbench for data_bus_bridge: instance 0 uses the default timeout,
// instance 1 uses TIMEOUT_CYCLES = 4. Expected completions are pushed to a
// scoreboard queue when an access is driven and popped at its DONE cycle.
module tb_data_bus_bridge;

  localparam int unsigned TimeoutL = 255;
  localparam int unsigned TimeoutT = 4;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] ea;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]       coreRead, coreWrite, coreStall, memReq, memWe, memAck, busError;
  logic [1:0][3:0]  coreBe, memBe;
  logic [1:0][31:0] coreAddr, coreWdata, coreRdata, memAddr, memWdata, memRdata, errAddr;

  logic [1:0][31:0] modelRd;
  logic [1:0][31:0] modelErrAddr;
  exp_t             sbQ[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_bridge dutL (
    .iCLK           (clk),
    .iRST           (rst),
    .iCoreRead      (coreRead[0]),
    .iCoreWrite     (coreWrite[0]),
    .iCoreByteEnable(coreBe[0]),
    .iCoreAddress   (coreAddr[0]),
    .iCoreWriteData (coreWdata[0]),
    .oCoreReadData  (coreRdata[0]),
    .oCoreStall     (coreStall[0]),
    .oMemReq        (memReq[0]),
    .oMemWe         (memWe[0]),
    .oMemByteEnable (memBe[0]),
    .oMemAddress    (memAddr[0]),
    .oMemWriteData  (memWdata[0]),
    .iMemReadData   (memRdata[0]),
    .iMemAck        (memAck[0]),
    .oBusError      (busError[0]),
    .oErrAddress    (errAddr[0])
  );

  data_bus_bridge #(
    .TIMEOUT_CYCLES(TimeoutT)
  ) dutT (
    .iCLK           (clk),
    .iRST           (rst),
    .iCoreRead      (coreRead[1]),
    .iCoreWrite     (coreWrite[1]),
    .iCoreByteEnable(coreBe[1]),
    .iCoreAddress   (coreAddr[1]),
    .iCoreWriteData (coreWdata[1]),
    .oCoreReadData  (coreRdata[1]),
    .oCoreStall     (coreStall[1]),
    .oMemReq        (memReq[1]),
    .oMemWe         (memWe[1]),
    .oMemByteEnable (memBe[1]),
    .oMemAddress    (memAddr[1]),
    .oMemWriteData  (memWdata[1]),
    .iMemReadData   (memRdata[1]),
    .iMemAck        (memAck[1]),
    .oBusError      (busError[1]),
    .oErrAddress    (errAddr[1])
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full access on instance d. ackN = number of BUSY cycles before the ack
  // (ack during BUSY cycle ackN+1); ackN < 0 means never ack.
  task automatic doAccess(input int d, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] ackData,
                          input int ackN);
    exp_t        e;
    exp_t        got;
    int          busyCycles;
    int          tmo;
    tmo = (d == 0) ? int'(TimeoutL) : int'(TimeoutT);
    if (ackN >= 0 && ackN < tmo) begin
      busyCycles = ackN + 1;
      e.err      = 1'b0;
      if (!wr) modelRd[d] = ackData;
    end else begin
      busyCycles      = tmo;
      e.err           = 1'b1;
      modelRd[d]      = 32'h0;
      modelErrAddr[d] = addr;
    end
    e.rd = modelRd[d];
    e.ea = modelErrAddr[d];

    @(posedge clk); #1;
    coreRead[d]  = rd;
    coreWrite[d] = wr;
    coreAddr[d]  = addr;
    coreBe[d]    = be;
    coreWdata[d] = wdata;
    sbQ.push_back(e);
    @(negedge clk);
    checkEq("detect_stall", 32'(coreStall[d]), 32'd1);
    checkEq("detect_req", 32'(memReq[d]), 32'd0);

    for (int k = 1; k <= busyCycles; k++) begin
      @(posedge clk); #1;
      // Core side may wander while stalled; memory side must not follow.
      coreRead[d]  = 1'($urandom_range(0, 1));
      coreWrite[d] = 1'($urandom_range(0, 1));
      coreAddr[d]  = $urandom;
      coreBe[d]    = 4'($urandom);
      coreWdata[d] = $urandom;
      memAck[d]    = (k == ackN + 1);
      memRdata[d]  = (k == ackN + 1) ? ackData : $urandom;
      @(negedge clk);
      checkEq("busy_req", 32'(memReq[d]), 32'd1);
      checkEq("busy_stall", 32'(coreStall[d]), 32'd1);
      checkEq("busy_we", 32'(memWe[d]), 32'(wr));
      checkEq("busy_addr", memAddr[d], addr);
      checkEq("busy_be", 32'(memBe[d]), 32'(be));
      checkEq("busy_wdata", memWdata[d], wdata);
      checkEq("busy_err", 32'(busError[d]), 32'd0);
    end

    @(posedge clk); #1;
    memAck[d]    = 1'b0;
    coreRead[d]  = 1'b0;
    coreWrite[d] = 1'b0;
    @(negedge clk);
    checkEq("done_req", 32'(memReq[d]), 32'd0);
    checkEq("done_stall", 32'(coreStall[d]), 32'd0);
    if (sbQ.size() == 0) begin
      checkEq("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sbQ.pop_front();
      checkEq("done_rdata", coreRdata[d], got.rd);
      checkEq("done_buserr", 32'(busError[d]), 32'(got.err));
      checkEq("done_erraddr", errAddr[d], got.ea);
    end
  endtask

  // Idle cycle on instance d, optionally with a stray ack that must be ignored.
  task automatic idleCycle(input int d, input logic ack);
    @(posedge clk); #1;
    memAck[d]   = ack;
    memRdata[d] = $urandom;
    @(posedge clk); #1;
    memAck[d] = 1'b0;
    @(negedge clk);
    checkEq("idle_stall", 32'(coreStall[d]), 32'd0);
    checkEq("idle_req", 32'(memReq[d]), 32'd0);
    checkEq("idle_rdata", coreRdata[d], modelRd[d]);
    checkEq("idle_buserr", 32'(busError[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    coreRead     = '0;
    coreWrite    = '0;
    coreBe       = '0;
    coreAddr     = '0;
    coreWdata    = '0;
    memRdata     = '0;
    memAck       = '0;
    modelRd      = '0;
    modelErrAddr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkEq("rst_stall", 32'(coreStall[d]), 32'd0);
      checkEq("rst_req", 32'(memReq[d]), 32'd0);
      checkEq("rst_we", 32'(memWe[d]), 32'd0);
      checkEq("rst_be", 32'(memBe[d]), 32'd0);
      checkEq("rst_addr", memAddr[d], 32'd0);
      checkEq("rst_wdata", memWdata[d], 32'd0);
      checkEq("rst_rdata", coreRdata[d], 32'd0);
      checkEq("rst_buserr", 32'(busError[d]), 32'd0);
      checkEq("rst_erraddr", errAddr[d], 32'd0);
    end

    // Zero-wait read.
    doAccess(0, 1'b1, 1'b0, 32'h1000_0004, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
    idleCycle(0, 1'b0);
    // Wait-state write: ack after 5 BUSY cycles.
    doAccess(0, 1'b0, 1'b1, 32'h1000_0010, 4'hF, 32'h1234_5678, 32'h5555_0000, 5);
    // Timeout read on the short-timeout instance, then check the pulse ends.
    doAccess(1, 1'b1, 1'b0, 32'hFF20_0000, 4'hF, 32'h0, 32'h0, -1);
    idleCycle(1, 1'b0);
    // Ack exactly at the terminal count wins over the timeout.
    doAccess(1, 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'hA5A5_A5A5, 3);
    // Back-to-back load then store, then a stray ack while idle.
    doAccess(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'h1111_2222, 2);
    doAccess(0, 1'b0, 1'b1, 32'h0000_0104, 4'h3, 32'h0000_BEEF, 32'h7777_7777, 1);
    idleCycle(0, 1'b1);
    // Read and write together behave as a write.
    doAccess(0, 1'b1, 1'b1, 32'h0000_0200, 4'b0011, 32'h0000_CAFE, 32'h0BAD_0BAD, 0);
    // Timed-out write clears read data and records the address.
    doAccess(1, 1'b0, 1'b1, 32'h0000_0300, 4'hC, 32'hFACE_0000, 32'h0, -1);
    idleCycle(1, 1'b0);

    // Reset pulse during BUSY.
    @(posedge clk); #1;
    coreRead[0] = 1'b1;
    coreAddr[0] = 32'h0000_0400;
    coreBe[0]   = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkEq("pre_rst_req", 32'(memReq[0]), 32'd1);
    coreRead[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelRd      = '0;
    modelErrAddr = '0;
    checkEq("midrst_req", 32'(memReq[0]), 32'd0);
    checkEq("midrst_stall", 32'(coreStall[0]), 32'd0);
    checkEq("midrst_addr", memAddr[0], 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idleCycle(0, 1'b1);
    doAccess(0, 1'b1, 1'b0, 32'h0000_0500, 4'hF, 32'h0, 32'h600D_F00D, 1);
    idleCycle(0, 1'b0);

    checkEq("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Multi-cycle bridge between the single-cycle core's data bus (Dw* signals) and a slower handshaked memory/peripheral bus (req/ack). It captures each core load or store, holds it on the memory side until acknowledged or timed out, and stalls the core through a combinational stall output that gates the PC, register-file and CSR clock enables. It sits directly downstream of the core datapath, in front of the data memory and MMIO decoder.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without iMemAck before the access is aborted; legal range 1..65535.
- iCLK  in  1  core clock.
- iRST  in  1  reset; asynchronous, active-high.
- iCoreRead  in  1  core load request (DwReadEnable).
- iCoreWrite  in  1  core store request (DwWriteEnable).
- iCoreByteEnable  in  4  byte lanes (DwByteEnable).
- iCoreAddress  in  32  byte address (DwAddress).
- iCoreWriteData  in  32  store data, already lane-aligned.
- oCoreReadData  out  32  load data returned to the core (DwReadData).
- oCoreStall  out  1  hold the core; combinational.
- oMemReq  out  1  memory-side request, registered.
- oMemWe  out  1  1 = write, 0 = read; valid while oMemReq is high.
- oMemByteEnable  out  4  captured byte enables.
- oMemAddress  out  32  captured address.
- oMemWriteData  out  32  captured write data.
- iMemReadData  in  32  memory read data; sampled on the iMemAck cycle.
- iMemAck  in  1  one-cycle completion strobe.
- oBusError  out  1  one-cycle pulse on timeout.
- oErrAddress  out  32  address of the last timed-out access.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- Define access = iCoreRead | iCoreWrite.
- IDLE, access = 1:
  - capture address, byte enables, write data and oMemWe = iCoreWrite;
  - clear the timeout counter;
  - go to BUSY.
  - If read and write are both high, the access is a write.
- BUSY:
  - oMemReq = 1 and all memory-side outputs are held constant.
  - iMemAck = 1: latch iMemReadData into the read-data register (reads only; writes leave it unchanged), then go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack:
    - read-data register <= 0;
    - oBusError pulses for 1 cycle;
    - oErrAddress <= captured address;
    - go to DONE.
- DONE:
  - oMemReq = 0 and oCoreStall = 0; the core retires the instruction at this edge.
  - Go to IDLE unconditionally.
- oCoreStall = (IDLE & access) | BUSY.
- oCoreReadData = read-data register, always.
- iMemAck outside BUSY is ignored.
- Counter width is clog2(TIMEOUT_CYCLES)+1. It saturates and never wraps.

## Timing
- Reset values:
  - state IDLE;
  - oMemReq, oMemWe, oBusError = 0;
  - oMemByteEnable = 0;
  - oMemAddress, oMemWriteData, oCoreReadData, oErrAddress = 0;
  - oCoreStall = 0 while the core inputs are idle.
- Access latency for an ack arriving N cycles after oMemReq rises (N ≥ 0):
  - cycle 0: IDLE, stall high;
  - cycle 1: oMemReq rises;
  - cycle 1+N: ack;
  - cycle 2+N: DONE, stall low.
  - Minimum 3 core cycles per access.
- Timeout: DONE is entered TIMEOUT_CYCLES+1 cycles after the IDLE detect cycle. oBusError is high during the DONE cycle.
- Back-to-back accesses: a new access is detected no earlier than the cycle after DONE. DONE never re-captures.
- Ack and timeout in the same cycle: ack wins and oBusError stays low.
- Reset asserted mid-access:
  - oMemReq drops asynchronously, state goes to IDLE, captured data is discarded;
  - no ack is expected afterwards;
  - a late iMemAck is ignored.
- Core inputs may change while stalled. Memory-side outputs must still not change.

## Structure
- Shared package: FSM state encoding (IDLE/BUSY/DONE), default timeout constant DBUS_TIMEOUT_DEFAULT = 255, and bus-error cause code for the exception unit.
- One sub-module, bus_timeout_counter, with clear, enable, saturating count and a terminal-count output. The FSM and capture registers live in the top.

## Test plan
- Zero-wait read: read 0x1000_0004, ack the first BUSY cycle with data 0xDEAD_BEEF -> stall high for exactly 2 cycles, DONE on cycle 2, oCoreReadData = 0xDEAD_BEEF, oBusError = 0.
- Wait-state write: sw of 0x1234_5678 to 0x1000_0010, byte enables 4'b1111, ack after 5 BUSY cycles -> oMemReq high for 6 cycles, oMemWe = 1, outputs stable throughout, stall released on cycle 7.
- Timeout: TIMEOUT_CYCLES = 4, read 0xFF20_0000, no ack -> DONE at cycle 5, oCoreReadData = 0, oBusError one-cycle pulse, oErrAddress = 0xFF20_0000.
- Ack at the terminal count with TIMEOUT_CYCLES = 4 and data 0xA5A5_A5A5 -> data latched, no oBusError.
- Back-to-back lw/sw -> second oMemReq rises exactly 2 cycles after the first DONE; a stray iMemAck in IDLE has no effect.
- Reset pulse during BUSY -> oMemReq low immediately, state IDLE, a later ack is ignored, and the next access behaves normally.
